mfp_sdram_arbiter: RTL
======================

# mfp_sdram_arbiter

Two-requester command/data arbiter in the SDRAM clock domain. It sits between two sets of clock-crossing FIFOs (port 0: CPU AHB-Lite bridge, port 1: DMA/video master) and the single `mfp_sdram` controller. It grants one complete single-word transaction at a time. While a port is granted, its command, write-data and read-data FIFO paths are muxed onto the controller's FIFO interface, so the controller needs no changes.

## Interface
- `PRIORITY_MODE`, default 0: 0 = round-robin; 1 = fixed priority to port 0 with a starvation limit.
- `STARVE_LIMIT`, default 4: in mode 1, the number of consecutive port-0 grants while port 1 waits, after which port 1 is forced. Range 1..15.
- `SDRAM_CLK` in, 1: the only clock.
- `SDRAM_RSTn` in, 1: reset, asynchronous, active-low.
- `C0_REMPTY`/`C1_REMPTY` in, 1: port command FIFO empty.
- `C0_RDATA`/`C1_RDATA` in, `SDRAM_CMD_FIFO_DATA_WIDTH` (36): command word, with [31:0] addr, [34:32] size, [35] write.
- `C0_REN`/`C1_REN` out, 1: port command pop.
- `W0_REMPTY`/`W1_REMPTY` in, 1; `W0_RDATA`/`W1_RDATA` in, 32; `W0_REN`/`W1_REN` out, 1: port write-data FIFO read side.
- `R0_WFULL`/`R1_WFULL` in, 1; `R0_WEN`/`R1_WEN` out, 1; `R0_WDATA`/`R1_WDATA` out, 32: port read-data FIFO write side.
- `CFIFO_REMPTY` out, 1; `CFIFO_RDATA` out, 36; `CFIFO_REN` in, 1: the controller's view of the command FIFO.
- `WFIFO_REMPTY` out, 1; `WFIFO_RDATA` out, 32; `WFIFO_REN` in, 1: the controller's view of the write-data FIFO.
- `RFIFO_WFULL` out, 1; `RFIFO_WDATA` in, 32; `RFIFO_WEN` in, 1: the controller's view of the read-data FIFO.
- `GRANT` out, 2: one-hot active grant; 00 when idle.

## Operation
- The FIFOs are show-ahead: RDATA is valid while REMPTY=0, and REN pops the entry.
- States:
  - `S_IDLE`: no grant; all downstream EMPTY=1, FULL=1.
  - `S_CMD`: granted port's command exposed; wait for `CFIFO_REN`.
  - `S_WDATA`: granted port's write FIFO exposed; wait for `WFIFO_REN`.
  - `S_RDATA`: granted port's read FIFO exposed; wait for `RFIFO_WEN`.
- Transitions:
  - `S_IDLE` to `S_CMD` when any `Cn_REMPTY`=0; the winner is registered into `GRANT`.
  - `S_CMD` on `CFIFO_REN`: go to `S_WDATA` if `CFIFO_RDATA[35]`=1, else to `S_RDATA`. The write bit is latched.
  - `S_WDATA` on `WFIFO_REN` returns to `S_IDLE`.
  - `S_RDATA` on `RFIFO_WEN` returns to `S_IDLE`.
- Muxing is combinational from `GRANT`/state:
  - In `S_CMD`: `CFIFO_REMPTY`=`Cg_REMPTY`, `CFIFO_RDATA`=`Cg_RDATA`, `Cg_REN`=`CFIFO_REN`.
  - The W and R paths are muxed the same way, in `S_WDATA` and `S_RDATA` only.
  - All non-granted RENs and WENs are 0.
  - `Rn_WDATA` is always `RFIFO_WDATA`.
- Round-robin (mode 0):
  - A 1-bit `last` pointer records the last port served.
  - When both ports request, the port other than `last` wins.
  - `last` updates on entry to `S_CMD`.
- Fixed priority (mode 1):
  - Port 0 wins unless `starve_cnt` ≥ `STARVE_LIMIT` with port 1 requesting.
  - `starve_cnt` (4 bits) increments on each port-0 grant made while port 1 requests, and clears on any port-1 grant.
  - It saturates at 15.
- Controller strobes outside their matching state are ignored and not forwarded; this is a controller protocol error.

## Timing
- Reset values:
  - State `S_IDLE`, `GRANT`=00, `last`=1 (port 0 wins first tie), `starve_cnt`=0.
  - `CFIFO_REMPTY`=1, `WFIFO_REMPTY`=1, `RFIFO_WFULL`=1.
  - All `Cn_REN`, `Wn_REN`, `Rn_WEN`=0.
  - `CFIFO_RDATA`/`WFIFO_RDATA`=0 when not granted.
- Latency: a request sampled in `S_IDLE` at edge t is visible as `CFIFO_REMPTY`=0 after edge t+1.
- There is one `S_IDLE` bubble cycle between transactions.
- A request arriving in the same cycle as a completion is sampled in the following `S_IDLE`; it is not lost.
- Back-pressure: an empty granted W FIFO or a full granted R FIFO holds the state indefinitely; there is no timeout.
- Asynchronous reset mid-transaction: return to `S_IDLE` immediately and drop the in-flight transaction. The upstream FIFOs and `mfp_sdram` are reset from the same `SDRAM_RSTn`.

## Structure
- Add to `mfp_sdram.vh`:
  - `SDRAM_CMD_WRITE_BIT` (35), `SDRAM_CMD_SIZE_LSB`/`MSB` (32/34).
  - Arbiter state encodings `SDRAM_ARB_S_*`.
- State, `GRANT`, `last`, `starve_cnt` and the write flag use `mfp_register_r`.
- One sub-module, `mfp_sdram_arb_pick`: combinational winner selection from (req[1:0], `last`, `starve_cnt`, mode). It is kept separate so it can be checked exhaustively.

## Test plan
- Port 0 alone writes addr 0x0000_0100, data 0xDEADBEEF → `GRANT`=01 one cycle after the request. The controller sees cmd bit35=1 then data 0xDEADBEEF. `W0_REN` pulses once and `W1_REN` stays 0.
- Port 1 alone reads 0x0000_0200; the controller returns 0x12345678 → `R1_WEN`=1 with `R1_WDATA`=0x12345678, `R0_WEN`=0, then `GRANT`=00.
- Mode 0, both ports continuously requesting 6 reads → grant order 0,1,0,1,0,1, with exactly one `S_IDLE` cycle between grants.
- Mode 1, `STARVE_LIMIT`=4, both ports continuously requesting → grant order 0,0,0,0,1,0,0,0,0,1.
- Granted port 0 read with `R0_WFULL`=1 for 10 cycles → `RFIFO_WFULL`=1 and the state holds `S_RDATA`. On release, `R0_WEN` follows `RFIFO_WEN` and port 1 is served next.
- Assert `SDRAM_RSTn`=0 during `S_WDATA` → all outputs at reset values asynchronously. After release, a pending port 1 command is granted with `GRANT`=10.

Source files
------------

// File: rtl/mfp_sdram_arbiter_pkg.sv
// Shared constants and types for the two-port SDRAM command/data arbiter.
package mfp_sdram_arbiter_pkg;

  localparam int unsigned SDRAM_CMD_FIFO_DATA_WIDTH = 36;
  localparam int unsigned SDRAM_CMD_WRITE_BIT       = 35;
  localparam int unsigned SDRAM_CMD_SIZE_LSB        = 32;
  localparam int unsigned SDRAM_CMD_SIZE_MSB        = 34;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMD   = 2'd1,
    S_WDATA = 2'd2,
    S_RDATA = 2'd3
  } arb_state_e;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mfp_sdram_arb_pick.sv
// Combinational winner selection between the two requesters.
module mfp_sdram_arb_pick
  import mfp_sdram_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic [1:0] req,
  input  logic       last,
  input  logic [3:0] starve_cnt,
  input  logic       mode,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      // Contention: round-robin favours the port not served last; fixed
      // priority favours port 0 until port 1 has waited long enough.
      2'b11:   winner = mode ? (starve_cnt >= 4'(STARVE_LIMIT)) : ~last;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/mfp_sdram_arbiter.sv
// Grants one single-word SDRAM transaction at a time to port 0 or port 1 and
// muxes that port's command, write-data and read-data FIFOs onto the controller.
module mfp_sdram_arbiter
  import mfp_sdram_arbiter_pkg::*;
#(
  parameter int unsigned PRIORITY_MODE = 0,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic        SDRAM_CLK,
  input  logic        SDRAM_RSTn,
  input  logic        C0_REMPTY,
  input  logic [35:0] C0_RDATA,
  output logic        C0_REN,
  input  logic        C1_REMPTY,
  input  logic [35:0] C1_RDATA,
  output logic        C1_REN,
  input  logic        W0_REMPTY,
  input  logic [31:0] W0_RDATA,
  output logic        W0_REN,
  input  logic        W1_REMPTY,
  input  logic [31:0] W1_RDATA,
  output logic        W1_REN,
  input  logic        R0_WFULL,
  output logic        R0_WEN,
  output logic [31:0] R0_WDATA,
  input  logic        R1_WFULL,
  output logic        R1_WEN,
  output logic [31:0] R1_WDATA,
  output logic        CFIFO_REMPTY,
  output logic [35:0] CFIFO_RDATA,
  input  logic        CFIFO_REN,
  output logic        WFIFO_REMPTY,
  output logic [31:0] WFIFO_RDATA,
  input  logic        WFIFO_REN,
  output logic        RFIFO_WFULL,
  input  logic [31:0] RFIFO_WDATA,
  input  logic        RFIFO_WEN,
  output logic [1:0]  GRANT
);

  arb_state_e  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        wr_q, wr_d;

  logic [1:0]  req;
  logic        pick_valid;
  logic        pick_winner;
  logic        gport;
  logic [35:0] cmd_word;
  logic        w_phase;
  logic        r_phase;

  assign req   = {~C1_REMPTY, ~C0_REMPTY};
  assign gport = grant_q[1];

  mfp_sdram_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .req        (req),
    .last       (last_q),
    .starve_cnt (starve_cnt_q),
    .mode       (PRIORITY_MODE != 0),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  always_ff @(posedge SDRAM_CLK or negedge SDRAM_RSTn) begin
    if (!SDRAM_RSTn) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_q       <= 1'b1;
      starve_cnt_q <= '0;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      starve_cnt_q <= starve_cnt_d;
      wr_q         <= wr_d;
    end
  end

  assign cmd_word = gport ? C1_RDATA : C0_RDATA;
  assign w_phase  = (state_q == S_WDATA) &&  wr_q;
  assign r_phase  = (state_q == S_RDATA) && !wr_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    starve_cnt_d = starve_cnt_q;
    wr_d         = wr_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d = S_CMD;
          grant_d = port_onehot(pick_winner);
          last_d  = pick_winner;
          if (PRIORITY_MODE != 0) begin
            if (pick_winner)
              starve_cnt_d = '0;
            else if (req[1] && (starve_cnt_q != 4'hF))
              starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end
      end
      S_CMD: begin
        if (CFIFO_REN) begin
          wr_d    = cmd_word[SDRAM_CMD_WRITE_BIT];
          state_d = cmd_word[SDRAM_CMD_WRITE_BIT] ? S_WDATA : S_RDATA;
        end
      end
      S_WDATA: begin
        if (WFIFO_REN) begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
      S_RDATA: begin
        if (RFIFO_WEN) begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Strobes from the controller only reach the granted port in the matching state.
  always_comb begin
    CFIFO_REMPTY = 1'b1;
    CFIFO_RDATA  = '0;
    WFIFO_REMPTY = 1'b1;
    WFIFO_RDATA  = '0;
    RFIFO_WFULL  = 1'b1;
    C0_REN       = 1'b0;
    C1_REN       = 1'b0;
    W0_REN       = 1'b0;
    W1_REN       = 1'b0;
    R0_WEN       = 1'b0;
    R1_WEN       = 1'b0;
    if (state_q == S_CMD) begin
      CFIFO_REMPTY = gport ? C1_REMPTY : C0_REMPTY;
      CFIFO_RDATA  = cmd_word;
      C0_REN       = ~gport & CFIFO_REN;
      C1_REN       =  gport & CFIFO_REN;
    end
    if (w_phase) begin
      WFIFO_REMPTY = gport ? W1_REMPTY : W0_REMPTY;
      WFIFO_RDATA  = gport ? W1_RDATA  : W0_RDATA;
      W0_REN       = ~gport & WFIFO_REN;
      W1_REN       =  gport & WFIFO_REN;
    end
    if (r_phase) begin
      RFIFO_WFULL  = gport ? R1_WFULL : R0_WFULL;
      R0_WEN       = ~gport & RFIFO_WEN;
      R1_WEN       =  gport & RFIFO_WEN;
    end
  end

  assign R0_WDATA = RFIFO_WDATA;
  assign R1_WDATA = RFIFO_WDATA;
  assign GRANT    = grant_q;

endmodule
